// File: rtl/enc_pkg.sv
// Shared types and constants for the 16-to-4 streaming encoder.
package enc_pkg;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned IDX_W = 4;

  // Fault-injected build: index bit XFAULT_MASK_BIT is cleared whenever
  // index bit XFAULT_GATE_BIT is set.
  localparam int unsigned XFAULT_GATE_BIT = 3;
  localparam int unsigned XFAULT_MASK_BIT = 2;

  // EMPTY: main empty; HOLD1: main full; HOLD2: main and skid full.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHold1 = 2'd1,
    StHold2 = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_enc16.sv
// Combinational 16-to-4 priority encoder with one-hot error flag.
// Build macro ENC_XFAULT3_EN: when defined, idx bit 2 is forced low
// whenever idx bit 3 is set (indices 12-15 report as 8-11).
module onehot_enc16
  import enc_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic [IN_W-1:0]  d_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             err_o
);

  logic [IDX_W-1:0] raw_idx;

  // Priority search: the last set bit visited wins, so scan direction picks the priority.
  always_comb begin
    raw_idx = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < IN_W; i++) begin
        if (d_i[i]) raw_idx = IDX_W'(i);
      end
    end else begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (d_i[i]) raw_idx = IDX_W'(i);
      end
    end
  end

  // Error whenever the word is not exactly one-hot; optional index fault gating.
  always_comb begin
    err_o = ($countones(d_i) != 1);
    idx_o = raw_idx;
`ifdef ENC_XFAULT3_EN
    if (raw_idx[XFAULT_GATE_BIT]) idx_o[XFAULT_MASK_BIT] = 1'b0;
`endif
  end

endmodule

// File: rtl/encoder_16x4_stream.sv
// Streaming 16-to-4 encoder with a 2-entry skid buffer and saturating
// error counter. Build macro ENC_XFAULT3_EN selects the fault-injected
// encoder variant; buffering and counting are identical in both builds.
module encoder_16x4_stream
  import enc_pkg::*;
#(
  parameter bit          PRIO_HIGH = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  d_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] d_out,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] main_idx_q, main_idx_d, skid_idx_q, skid_idx_d;
  logic             main_err_q, main_err_d, skid_err_q, skid_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_err;
  logic             accept, xfer;

  onehot_enc16 #(
    .PRIO_HIGH (PRIO_HIGH)
  ) u_enc (
    .d_i   (d_in),
    .idx_o (enc_idx),
    .err_o (enc_err)
  );

  assign in_ready  = (state_q != StHold2);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign d_out     = main_idx_q;
  assign err       = main_err_q;
  assign err_cnt   = cnt_q;

  // Skid-buffer FSM: route accepted words into main or skid, refill main from skid.
  always_comb begin
    state_d    = state_q;
    main_idx_d = main_idx_q;
    main_err_d = main_err_q;
    skid_idx_d = skid_idx_q;
    skid_err_d = skid_err_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_idx_d = enc_idx;
          main_err_d = enc_err;
          state_d    = StHold1;
        end
      end
      StHold1: begin
        if (accept && xfer) begin
          main_idx_d = enc_idx;
          main_err_d = enc_err;
        end else if (accept) begin
          skid_idx_d = enc_idx;
          skid_err_d = enc_err;
          state_d    = StHold2;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StHold2: begin
        if (xfer) begin
          main_idx_d = skid_idx_q;
          main_err_d = skid_err_q;
          state_d    = StHold1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Error counter: clear beats increment; saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (accept && enc_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and data registers; async reset discards both buffer entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_idx_q <= '0;
      main_err_q <= 1'b0;
      skid_idx_q <= '0;
      skid_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_idx_q <= main_idx_d;
      main_err_q <= main_err_d;
      skid_idx_q <= skid_idx_d;
      skid_err_q <= skid_err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_encoder_16x4_stream.sv
// Directed self-checking bench for encoder_16x4_stream, plus a decoder loopback.
module tb_encoder_16x4_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  d_out;
  logic        err;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        err_clr = 1'b0;
  logic [7:0]  err_cnt;

  // Low-priority instance shares the input stream and never stalls.
  logic        in_ready_lo, err_lo, out_valid_lo;
  logic [3:0]  d_out_lo;
  logic [7:0]  err_cnt_lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  encoder_16x4_stream #(.PRIO_HIGH(1'b1), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_out     (d_out),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  encoder_16x4_stream #(.PRIO_HIGH(1'b0), .CNT_W(8)) u_dut_lo (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready_lo),
    .d_out     (d_out_lo),
    .err       (err_lo),
    .out_valid (out_valid_lo),
    .out_ready (1'b1),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt_lo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Index a one-hot word of bit i should report in this build.
  function automatic logic [3:0] exp_idx(input int i);
    logic [3:0] v;
    v = 4'(i);
`ifdef ENC_XFAULT3_EN
    if (v[3]) v[2] = 1'b0;
`endif
    return v;
  endfunction

  logic [3:0] sb[$];
  logic [3:0] sent;
  logic       acc, xf;

  initial begin
    // Reset state
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_d_out", 32'(d_out), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // One-hot sweep, one word per cycle, no backpressure
    for (int i = 0; i < 16; i++) begin
      d_in = 16'(1) << i;
      in_valid = 1'b1;
      step();
      check_eq($sformatf("sweep_idx%0d", i), 32'(d_out), 32'(exp_idx(i)));
      check_eq($sformatf("sweep_err%0d", i), 32'(err), 32'd0);
      check_eq($sformatf("sweep_vld%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check_eq("sweep_drained", 32'(out_valid), 32'd0);
    check_eq("sweep_err_cnt", 32'(err_cnt), 32'd0);

    // Zero word
    d_in = 16'h0000;
    in_valid = 1'b1;
    step();
    check_eq("zero_idx", 32'(d_out), 32'd0);
    check_eq("zero_err", 32'(err), 32'd1);
    check_eq("zero_err_cnt", 32'(err_cnt), 32'd1);

    // Multi-hot resolution in both priorities
    d_in = 16'h0081;
    step();
    check_eq("multi_hi_idx", 32'(d_out), 32'd7);
    check_eq("multi_hi_err", 32'(err), 32'd1);
    check_eq("multi_lo_idx", 32'(d_out_lo), 32'd0);
    check_eq("multi_lo_err", 32'(err_lo), 32'd1);
    check_eq("multi_err_cnt", 32'(err_cnt), 32'd2);
    in_valid = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Backpressure: three words against a stalled output
    out_ready = 1'b0;
    in_valid = 1'b1;
    d_in = 16'h0004;
    step();
    check_eq("bp_ready1", 32'(in_ready), 32'd1);
    check_eq("bp_first", 32'(d_out), 32'd2);
    d_in = 16'h0010;
    step();
    check_eq("bp_ready2", 32'(in_ready), 32'd0);
    d_in = 16'h0400;
    step();
    check_eq("bp_stall_ready", 32'(in_ready), 32'd0);
    check_eq("bp_stall_idx", 32'(d_out), 32'd2);
    check_eq("bp_stall_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check_eq("bp_out2", 32'(d_out), 32'd4);
    step();
    check_eq("bp_out3", 32'(d_out), 32'(exp_idx(10)));
    in_valid = 1'b0;
    step();
    check_eq("bp_drained", 32'(out_valid), 32'd0);

    // Counter saturation, then clear beating an erroneous accept
    d_in = 16'h0003;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    check_eq("sat_err_cnt", 32'(err_cnt), 32'd255);
    check_eq("sat_idx", 32'(d_out), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("clr_prio_err_cnt", 32'(err_cnt), 32'd0);
    in_valid = 1'b0;
    step();

    // Async reset while in HOLD2
    out_ready = 1'b0;
    in_valid = 1'b1;
    d_in = 16'h0000;
    step();
    d_in = 16'h0002;
    step();
    in_valid = 1'b0;
    check_eq("hold2_ready", 32'(in_ready), 32'd0);
    check_eq("hold2_err_cnt", 32'(err_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    check_eq("arst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("arst_d_out", 32'(d_out), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    d_in = 16'h0020;
    in_valid = 1'b1;
    step();
    check_eq("post_rst_idx", 32'(d_out), 32'd5);
    check_eq("post_rst_vld", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();

    // Loopback from a 4x16 decoder with random stalls
    for (int c = 0; c < 400; c++) begin
      sent = 4'($urandom_range(0, 15));
      d_in = 16'(1) << sent;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = in_valid && in_ready;
      xf = out_valid && out_ready;
      if (xf) begin
        if (sb.size() == 0) begin
          check_eq("loop_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          check_eq("loop_idx", 32'(d_out), 32'(exp_idx(int'(sb.pop_front()))));
          check_eq("loop_err", 32'(err), 32'd0);
        end
      end
      if (acc) sb.push_back(sent);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8 && sb.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        check_eq("drain_idx", 32'(d_out), 32'(exp_idx(int'(sb.pop_front()))));
        check_eq("drain_err", 32'(err), 32'd0);
      end
      step();
    end
    check_eq("loop_empty", 32'(sb.size()), 32'd0);
    step();
    check_eq("loop_out_idle", 32'(out_valid), 32'd0);
    check_eq("loop_err_cnt", 32'(err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_16x4_stream.md
Name: encoder_16x4_stream

Overview:
- Streaming 16-to-4 encoder: accepts 16-bit one-hot words, returns the 4-bit index.
- Flags words that are not one-hot and counts those errors.
- Pairs with the team's 4x16 decoders for loopback and fault-coverage benches.
- Ready/valid on both sides; 2-entry skid buffer so the output can stall without losing data.

Parameters:
- PRIO_HIGH, 1, multi-hot resolution: 1 = highest set bit wins, 0 = lowest set bit wins.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- d_in  input  16  one-hot input word
- in_valid  input  1  d_in valid
- in_ready  output  1  block can accept d_in
- d_out  output  4  encoded index
- err  output  1  word accompanying d_out was not one-hot
- out_valid  output  1  d_out/err valid
- out_ready  input  1  downstream accepts
- err_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  saturating count of accepted erroneous words

Behaviour:
- Reset (rst_n low, async): d_out=0, err=0, out_valid=0, err_cnt=0, skid empty, state EMPTY.
- in_ready = !skid_valid, so it is 1 during and after reset.
- Accept: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Latency: an accepted word appears on d_out/err with out_valid=1 on the next cycle when the main register is free.
- Encoding, exactly one bit set: d_out = index, err=0.
- Encoding, zero bits set: d_out=0, err=1.
- Encoding, multiple bits set: d_out = highest index if PRIO_HIGH=1, else lowest index; err=1.
- States: EMPTY (main empty), HOLD1 (main full, skid empty), HOLD2 (main and skid full, in_ready=0).
- EMPTY: accept -> HOLD1.
- HOLD1, transfer without accept -> EMPTY.
- HOLD1, accept with transfer -> HOLD1; main takes the new word.
- HOLD1, accept without transfer -> HOLD2; the new word goes to skid.
- HOLD1, neither -> HOLD1.
- HOLD2, transfer -> HOLD1; skid moves to main. No accept is possible in HOLD2.
- Order is strictly FIFO; words are never dropped or duplicated.
- d_out/err stay stable while out_valid=1 and out_ready=0.
- err_cnt:
  - Increments by 1 on each accepted word with err=1; the new value is visible the next cycle.
  - Saturates at all-ones; no wrap.
  - err_clr has priority: if err_clr and an erroneous accept land in the same cycle, the result is 0.
- Reset mid-operation: contents of both buffers are discarded and all outputs return to reset values immediately.

Optional Feature:
- Macro ENC_XFAULT3_EN.
- Defined: fault-injected variant. After encoding, if d_out[3]=1 then d_out[2] is forced to 0 (indices 12-15 report as 8-11); err is unaffected.
- Undefined: fault-free encoding as above.
- Buffering, handshake and counter are identical in both builds.

Decomposition:
- Package enc_pkg holds:
  - state enum {EMPTY, HOLD1, HOLD2}
  - IN_W=16, IDX_W=4
  - the localparam for the fault mask bit (bit 2 gated by bit 3)
- Sub-module onehot_enc16: purely combinational (d_in, PRIO_HIGH) -> (idx, err), with the fault gating applied under ENC_XFAULT3_EN.
- The top level holds the skid/FSM and err_cnt.

Test Plan:
- Sweep 16'h0001..16'h8000, one per cycle, out_ready=1 -> d_out=0..15, err=0, one-cycle latency, err_cnt=0. With ENC_XFAULT3_EN: inputs 16'h1000..16'h8000 give d_out=8,9,10,11.
- d_in=16'h0000 -> d_out=0, err=1, err_cnt=1. d_in=16'h0081 gives d_out=7 with PRIO_HIGH=1, d_out=0 with PRIO_HIGH=0; err=1 in both cases.
- Backpressure:
  - Hold out_ready=0 and send 16'h0004, 16'h0010, 16'h0400.
  - in_ready drops after 2 accepts and the third word waits on in_valid.
  - Release out_ready -> outputs 2, 4, 10 in order.
- 300 accepted words of 16'h0003 with CNT_W=8 -> err_cnt saturates at 255. Then err_clr asserted with an erroneous accept in the same cycle -> err_cnt=0.
- Pull rst_n low in HOLD2 -> out_valid=0, in_ready=1, err_cnt=0 immediately, without waiting for a clock edge. After release, send 16'h0020 -> d_out=5.
- Loopback: fault-free 4x16 decoder feeds this block, 0..15 random with random out_ready -> index returned equals index sent, err=0 throughout.
